// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter state encoding and the default byte width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_arb_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational circular-priority pick: first set req_valid bit at or above rr_ptr, wrapping.
module uart_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any_valid
);

    always_comb begin
        int                  pos;
        logic [ID_WIDTH-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = ID_WIDTH'(pos);
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Optional launch watchdog and sticky timeout_err enabled by UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = $clog2(NUM_REQ),
    parameter int LAUNCH_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          active,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output tx_arb_state_t                 state_dbg
);

    // Handshake: a requester holds req_valid and its byte until it sees its
    // req_ready bit pulse for one cycle; the byte is captured on that same edge.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;

    logic [1:0]            state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  any_valid;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic [DATA_WIDTH-1:0] pick_data;
    logic                  grant_now;

    uart_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_now = (state == ST_IDLE) && !tx_busy && any_valid;
    assign next_ptr  = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_WIDTH'(1);
    assign state_dbg = tx_arb_state_t'(state);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(LAUNCH_TIMEOUT + 1);
    logic [TMO_W-1:0] launch_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            req_ready <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            launch_cnt  <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        req_ready <= pick_onehot;
                        tx_data   <= pick_data;
                        grant_id  <= pick_idx;
                        rr_ptr    <= next_ptr;
                        tx_valid  <= 1'b1;
                        active    <= 1'b1;
                        state     <= ST_LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        launch_cnt <= '0;
`endif
                    end
                end
                ST_LAUNCH: begin
                    if (tx_busy) begin
                        tx_valid <= 1'b0;
                        state    <= ST_BUSY;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Transmitter never acknowledged: abandon the byte and flag it.
                    else if (launch_cnt == TMO_W'(LAUNCH_TIMEOUT - 1)) begin
                        tx_valid    <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        launch_cnt <= launch_cnt + TMO_W'(1);
                    end
`endif
                end
                ST_BUSY: begin
                    if (!tx_busy) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter with hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam logic [1:0] S_I = IDLE;
    localparam logic [1:0] S_L = LAUNCH;
    localparam logic [1:0] S_B = BUSY;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    tx_arb_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH     (8),
        .NUM_REQ        (4),
        .ID_WIDTH       (2),
        .LAUNCH_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .state_dbg   (state_dbg)
    );

`ifndef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  e_ready;
        logic        e_txv;
        logic [7:0]  e_data;
        logic [1:0]  e_gid;
        logic        e_act;
        logic [1:0]  e_st;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic [31:0] data,
                                input logic busy, input logic [3:0] e_ready, input logic e_txv,
                                input logic [7:0] e_data, input logic [1:0] e_gid,
                                input logic e_act, input logic [1:0] e_st);
        vec_t v;
        v.rst = rst; v.rv = rv; v.data = data; v.busy = busy;
        v.e_ready = e_ready; v.e_txv = e_txv; v.e_data = e_data;
        v.e_gid = e_gid; v.e_act = e_act; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] rv, input logic [31:0] data,
                         input logic busy);
        reset     = rst;
        req_valid = rv;
        req_data  = data;
        tx_busy   = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_ready, input logic e_txv,
                             input logic [7:0] e_data, input logic [1:0] e_gid,
                             input logic e_act, input logic [1:0] e_st);
        check({tag, " req_ready"}, 32'(req_ready), 32'(e_ready));
        check({tag, " tx_valid"}, 32'(tx_valid), 32'(e_txv));
        check({tag, " tx_data"}, 32'(tx_data), 32'(e_data));
        check({tag, " grant_id"}, 32'(grant_id), 32'(e_gid));
        check({tag, " active"}, 32'(active), 32'(e_act));
        check({tag, " state"}, 32'(state_dbg), 32'(e_st));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        int         hold_ok;

        drive(1'b1, 4'h0, 32'h0, 1'b0);

        //            rst rv    data          busy ready txv data  gid act st
        vecs[0]  = mk(1, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 0, S_I);
        vecs[1]  = mk(0, 4'h1, 32'h0000_0055, 0, 4'h1, 1, 8'h55, 0, 1, S_L);
        vecs[2]  = mk(0, 4'h0, 32'h0000_0055, 0, 4'h0, 1, 8'h55, 0, 1, S_L);
        vecs[3]  = mk(0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h55, 0, 1, S_B);
        vecs[4]  = mk(0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h55, 0, 1, S_B);
        vecs[5]  = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h55, 0, 0, S_I);
        vecs[6]  = mk(0, 4'h2, 32'h0000_2200, 1, 4'h0, 0, 8'h55, 0, 0, S_I);
        vecs[7]  = mk(0, 4'h2, 32'h0000_2200, 1, 4'h0, 0, 8'h55, 0, 0, S_I);
        vecs[8]  = mk(0, 4'h2, 32'h0000_2200, 0, 4'h2, 1, 8'h22, 1, 1, S_L);
        vecs[9]  = mk(0, 4'h0, 32'h0000_2200, 1, 4'h0, 0, 8'h22, 1, 1, S_B);
        vecs[10] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h22, 1, 0, S_I);
        vecs[11] = mk(0, 4'h8, 32'h3300_0000, 0, 4'h8, 1, 8'h33, 3, 1, S_L);
        vecs[12] = mk(0, 4'h9, 32'h3400_0011, 1, 4'h0, 0, 8'h33, 3, 1, S_B);
        vecs[13] = mk(0, 4'h9, 32'h3400_0011, 0, 4'h0, 0, 8'h33, 3, 0, S_I);
        vecs[14] = mk(0, 4'h9, 32'h3400_0011, 0, 4'h1, 1, 8'h11, 0, 1, S_L);
        vecs[15] = mk(0, 4'h8, 32'h3400_0011, 1, 4'h0, 0, 8'h11, 0, 1, S_B);
        vecs[16] = mk(0, 4'h8, 32'h3400_0000, 0, 4'h0, 0, 8'h11, 0, 0, S_I);
        vecs[17] = mk(0, 4'h8, 32'h3400_0000, 0, 4'h8, 1, 8'h34, 3, 1, S_L);
        vecs[18] = mk(0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h34, 3, 1, S_B);
        vecs[19] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h34, 3, 0, S_I);
        vecs[20] = mk(0, 4'h1, 32'h00EE_0099, 1, 4'h0, 0, 8'h34, 3, 0, S_I);
        vecs[21] = mk(0, 4'h4, 32'h00EE_0099, 0, 4'h4, 1, 8'hEE, 2, 1, S_L);
        vecs[22] = mk(0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'hEE, 2, 1, S_B);
        vecs[23] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'hEE, 2, 0, S_I);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].data, vecs[i].busy);
            step();
            check_out($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_txv, vecs[i].e_data,
                      vecs[i].e_gid, vecs[i].e_act, vecs[i].e_st);
        end

        // All four requesters always valid: grants 0,1,2,3,0 from a fresh pointer.
        drive(1'b1, 4'h0, 32'h0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            g = 2'(k % 4);
            drive(1'b0, 4'hF, 32'hA3A2_A1A0, 1'b0);
            step();
            check_out($sformatf("rr%0d grant", k), 4'(1 << g), 1'b1, 8'hA0 + 8'(g), g, 1'b1, S_L);
            step();
            check($sformatf("rr%0d ready pulse", k), 32'(req_ready), 32'h0);
            check($sformatf("rr%0d launch hold", k), 32'(tx_valid), 32'h1);
            drive(1'b0, 4'hF, 32'hA3A2_A1A0, 1'b1);
            step();
            check($sformatf("rr%0d busy txv", k), 32'(tx_valid), 32'h0);
            check($sformatf("rr%0d busy state", k), 32'(state_dbg), 32'(S_B));
            drive(1'b0, 4'hF, 32'hA3A2_A1A0, 1'b0);
            step();
            check_out($sformatf("rr%0d gap", k), 4'h0, 1'b0, 8'hA0 + 8'(g), g, 1'b0, S_I);
        end

        // Reset while BUSY discards the byte and rewinds the pointer.
        drive(1'b0, 4'h4, 32'h003C_0000, 1'b0);
        step();
        check_out("rst grant", 4'h4, 1'b1, 8'h3C, 2'd2, 1'b1, S_L);
        drive(1'b0, 4'h4, 32'h003C_0000, 1'b1);
        step();
        check("rst pre state", 32'(state_dbg), 32'(S_B));
        drive(1'b1, 4'h4, 32'h003C_0000, 1'b1);
        step();
        check_out("rst busy", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, S_I);
        drive(1'b0, 4'hA, 32'h5500_6600, 1'b0);
        step();
        check_out("rst next", 4'h2, 1'b1, 8'h66, 2'd1, 1'b1, S_L);
        drive(1'b0, 4'h0, 32'h0, 1'b1);
        step();
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        step();
        check("rst frame end", 32'(state_dbg), 32'(S_I));

        // Launch with tx_busy never rising (rr_ptr is 2, so requester 0 wins).
        drive(1'b0, 4'h1, 32'h0000_0077, 1'b0);
        step();
        check_out("tmo grant", 4'h1, 1'b1, 8'h77, 2'd0, 1'b1, S_L);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        hold_ok = 1;
        for (int c = 1; c < 64; c++) begin
            step();
            if (tx_valid !== 1'b1 || state_dbg !== LAUNCH) hold_ok = 0;
        end
        check("tmo hold 64 cycles", 32'(hold_ok), 32'h1);
        check("tmo err early", 32'(timeout_err), 32'h0);
        step();
`ifdef UART_TX_ARB_TIMEOUT_EN
        check_out("tmo expire", 4'h0, 1'b0, 8'h77, 2'd0, 1'b0, S_I);
        check("tmo err set", 32'(timeout_err), 32'h1);
        drive(1'b0, 4'h2, 32'h0000_8800, 1'b0);
        step();
        check_out("tmo next grant", 4'h2, 1'b1, 8'h88, 2'd1, 1'b1, S_L);
        drive(1'b0, 4'h0, 32'h0, 1'b1);
        step();
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        step();
        check("tmo err sticky", 32'(timeout_err), 32'h1);
        drive(1'b1, 4'h0, 32'h0, 1'b0);
        step();
        check("tmo err reset", 32'(timeout_err), 32'h0);
`else
        for (int c = 0; c < 10; c++) begin
            step();
        end
        check_out("launch waits", 4'h0, 1'b1, 8'h77, 2'd0, 1'b1, S_L);
        drive(1'b0, 4'h0, 32'h0, 1'b1);
        step();
        check("launch late busy", 32'(state_dbg), 32'(S_B));
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        step();
        check("launch late done", 32'(active), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance between NUM_REQ byte producers (e.g. command, status and debug channels).
- Accepts one byte per grant from a requester using a valid/ready handshake, then drives the transmitter's valid/data inputs.
- Monitors the transmitter's busy flag and grants the next requester only after the frame completes.
- Sits directly above uart_tx in the UART top level.

Parameters:
- DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH.
- NUM_REQ, 4, number of requesters; range 2..16.
- ID_WIDTH, $clog2(NUM_REQ), width of grant_id.
- LAUNCH_TIMEOUT, 64, cycles allowed for tx_busy to rise after launch. Used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte available; held until the matching req_ready
- req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured
- tx_valid  output  1  drives uart_tx valid
- tx_data  output  DATA_WIDTH  drives uart_tx p_data_in
- tx_busy  input  1  from uart_tx temp_busy
- grant_id  output  ID_WIDTH  index of the current or most recent grant
- active  output  1  high from capture until frame completion
- timeout_err  output  1  sticky error flag; present only with UART_TX_ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state IDLE, rr_ptr 0.
  - req_ready 0, tx_valid 0, tx_data 0, grant_id 0, active 0, timeout_err 0.
  - Reset asserted mid-frame discards the held byte. uart_tx is reset by the same signal.
- States: IDLE, LAUNCH, BUSY.
- IDLE:
  - If tx_busy==0 and any req_valid is set, select the first set bit searching circularly from rr_ptr upward.
  - In the same cycle: pulse req_ready[g], register req_data slice g into tx_data, set grant_id=g, set rr_ptr=(g+1) mod NUM_REQ, and go to LAUNCH.
  - If tx_busy==1 in IDLE, make no grant.
- LAUNCH:
  - tx_valid=1, active=1.
  - Go to BUSY when tx_busy==1 is sampled; tx_valid drops in that same transition.
- BUSY:
  - tx_valid=0, active=1.
  - When tx_busy==0 is sampled, go to IDLE with active=0.
  - The earliest next grant is the following cycle, so there is a one-cycle minimum gap between grants.
- Latency: req_ready is registered one cycle after req_valid is seen in IDLE. tx_valid rises in that same cycle.
- Fairness: a requester that holds req_valid waits at most NUM_REQ-1 frames.
- Simultaneous requests: resolved purely by rr_ptr; there is no fixed priority.
- Wrap-around: rr_ptr=NUM_REQ-1 with a grant to NUM_REQ-1 sets rr_ptr to 0.
- Requester rules:
  - A requester dropping req_valid before its grant is simply skipped.
  - req_data changes after req_ready have no effect, because the byte is already held.
- tx_data stays stable from capture until the next capture.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in LAUNCH.
  - If tx_busy has not risen after LAUNCH_TIMEOUT cycles: drop tx_valid, set timeout_err=1 (sticky until reset), and return to IDLE. The byte is dropped.
- Without the macro: no counter and no timeout_err port; LAUNCH waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_arb_state_t {IDLE, LAUNCH, BUSY}.
  - Default DATA_WIDTH constant.
- One sub-module: uart_rr_arbiter.
  - Combinational circular priority pick from req_valid and rr_ptr.
  - Outputs a one-hot grant, the grant index and any_valid.
- The FSM, data register and pointer update live in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0001, data 0x55 → req_ready[0] pulses one cycle; tx_valid=1, tx_data=0x55 until tx_busy rises; active falls when tx_busy falls.
- All four requesters held valid with data 0xA0..0xA3 → grant order 0,1,2,3,0; each req_ready is a single pulse; at least one idle cycle between frames.
- Pointer wrap: after a grant to 3, req_valid=4'b1001 → next grant goes to 0, then 3.
- tx_busy forced high in IDLE with req_valid=4'b0010 → no req_ready until tx_busy=0; then grant 1 on the next cycle.
- Reset asserted in BUSY with tx_data=0x3C → next cycle tx_valid=0, tx_data=0, active=0, grant_id=0; rr_ptr=0, so the next grant goes to the lowest valid index.
- With UART_TX_ARB_TIMEOUT_EN and tx_busy tied 0, LAUNCH_TIMEOUT=64 → tx_valid drops after 64 cycles, timeout_err=1 and stays set; the next requester is still granted.
